// File: rtl/en_selector41_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | en_selector41_rr : registered 4-to-2 round-robin request encoder          |
// |   active-low requests in, {oS0,oS1} select + active-low valid out,        |
// |   grant held until iAck, optional grant timeout.                          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module en_selector41_rr #(
  parameter int TIMEOUT = 0
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iZ0,
  input  logic iZ1,
  input  logic iZ2,
  input  logic iZ3,
  input  logic iAck,
  output logic oS0,
  output logic oS1,
  output logic oC,
  output logic oOvf,
  output logic oTo
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic [3:0] prev_q, prev_d;
  logic [1:0] last_q, last_d;
  logic [1:0] sel_q, sel_d;
  logic       c_q, c_d;
  logic       ovf_q, ovf_d;
  logic       to_q, to_d;
  logic [7:0] cnt_q, cnt_d;

  logic [3:0] z;
  logic [3:0] req_edge;
  logic [3:0] clr;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       found;

  assign z        = {iZ3, iZ2, iZ1, iZ0};
  assign req_edge = prev_q & ~z;

  // Search order last+1, last+2, last+3, last (2-bit wrap gives the mod 4).
  always_comb begin
    pick  = last_q;
    cand  = last_q;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && pend_q[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    c_d     = c_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    clr     = 4'b0000;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          sel_d   = pick;
          c_d     = 1'b0;
          cnt_d   = 8'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (iAck) begin
          clr[sel_q] = 1'b1;
          last_d     = sel_q;
          c_d        = 1'b1;
          state_d    = IDLE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          // Withdrawn grant keeps its pending bit, so it competes again.
          c_d     = 1'b1;
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new edge beats a same-cycle clear of the same index.
    pend_d = (pend_q & ~clr) | req_edge;
    ovf_d  = |(req_edge & pend_q & ~clr);
    prev_d = z;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      pend_q  <= 4'b0000;
      prev_q  <= 4'b1111;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      c_q     <= 1'b1;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      prev_q  <= prev_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oS0  = sel_q[1];
  assign oS1  = sel_q[0];
  assign oC   = c_q;
  assign oOvf = ovf_q;
  assign oTo  = to_q;

endmodule
`default_nettype wire

// File: tb/tb_en_selector41_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_en_selector41_rr : directed scenarios plus random traffic against a   |
// |   behavioural model of the round-robin encoder (TIMEOUT = 4).            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_en_selector41_rr;

  localparam int TO = 4;

  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  logic iZ0 = 1'b1, iZ1 = 1'b1, iZ2 = 1'b1, iZ3 = 1'b1;
  logic iAck = 1'b0;
  logic oS0, oS1, oC, oOvf, oTo;

  int checks = 0;
  int failures = 0;

  en_selector41_rr #(.TIMEOUT(TO)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iZ0(iZ0), .iZ1(iZ1), .iZ2(iZ2), .iZ3(iZ3),
    .iAck(iAck),
    .oS0(oS0), .oS1(oS1), .oC(oC), .oOvf(oOvf), .oTo(oTo)
  );

  always #5 iClk = ~iClk;

  // Behavioural model: m_gidx = index currently granted, -1 when none.
  bit [3:0] m_pend, m_prev, m_old, m_edges, m_zz;
  int       m_last, m_sel, m_gidx, m_wait, m_cleared;
  bit       m_ovf, m_to;

  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      m_pend = 4'b0000; m_prev = 4'b1111; m_last = 3; m_sel = 0;
      m_gidx = -1; m_wait = 0; m_ovf = 0; m_to = 0;
    end else begin
      m_zz = {iZ3, iZ2, iZ1, iZ0};
      m_ovf = 0; m_to = 0; m_cleared = -1;
      m_old = m_pend;
      for (int n = 0; n < 4; n++) m_edges[n] = m_prev[n] && !m_zz[n];
      if (m_gidx < 0) begin
        if (m_old != 0) begin
          for (int k = 1; k <= 4; k++)
            if (m_gidx < 0 && m_old[(m_last + k) % 4]) m_gidx = (m_last + k) % 4;
          m_sel = m_gidx;
          m_wait = 0;
        end
      end else if (iAck) begin
        m_cleared = m_gidx; m_last = m_gidx; m_gidx = -1;
      end else if (TO != 0 && m_wait == TO - 1) begin
        m_gidx = -1; m_to = 1;
      end else begin
        m_wait++;
      end
      for (int n = 0; n < 4; n++)
        if (m_edges[n] && m_old[n] && n != m_cleared) m_ovf = 1;
      m_pend = m_old;
      if (m_cleared >= 0) m_pend[m_cleared] = 1'b0;
      m_pend = m_pend | m_edges;
      m_prev = m_zz;
    end
  end

  task automatic tick();
    @(posedge iClk);
    @(negedge iClk);
  endtask

  task automatic set_z(input logic [3:0] v);
    {iZ3, iZ2, iZ1, iZ0} = v;
  endtask

  task automatic do_reset();
    @(negedge iClk);
    iRst_n = 1'b0; iAck = 1'b0; set_z(4'b1111);
    tick(); tick();
    iRst_n = 1'b1;
  endtask

  task automatic wait_grant(input int limit, output bit ok);
    int n = 0;
    while (oC !== 1'b0 && n < limit) begin tick(); n++; end
    ok = (oC === 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({oC, oS0, oS1, oOvf, oTo} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_state got {oC,oS0,oS1,oOvf,oTo}=%b want 10000", {oC, oS0, oS1, oOvf, oTo});
    end
  endtask

  task automatic test_single();
    iZ2 = 1'b0;
    tick(); tick();
    checks++;
    if (oC !== 1'b0 || {oS0, oS1} !== 2'b10) begin
      failures++;
      $display("FAIL single_latency got oC=%b sel=%b want oC=0 sel=10", oC, {oS0, oS1});
    end
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    checks++;
    if (oC !== 1'b1) begin
      failures++;
      $display("FAIL single_release got oC=%b want 1", oC);
    end
    tick(); tick(); tick();
    checks++;
    if (oC !== 1'b1) begin
      failures++;
      $display("FAIL single_no_regrant got oC=%b want 1", oC);
    end
    iZ2 = 1'b1;
    tick();
  endtask

  task automatic test_all_four();
    bit ok;
    int low_seen = 0;
    do_reset();
    set_z(4'b0000);
    for (int k = 0; k < 4; k++) begin
      wait_grant(6, ok);
      checks++;
      if (!ok || {oS0, oS1} !== 2'(k)) begin
        failures++;
        $display("FAIL all_four_order step=%0d got oC=%b sel=%0d want oC=0 sel=%0d", k, oC, {oS0, oS1}, k);
      end
      iAck = 1'b1; tick(); iAck = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      if (oC === 1'b0) low_seen++;
      tick();
    end
    checks++;
    if (low_seen != 0) begin
      failures++;
      $display("FAIL all_four_drained got %0d low cycles of oC want 0", low_seen);
    end
    set_z(4'b1111);
    tick();
  endtask

  task automatic test_rr_after_3();
    bit ok;
    set_z(4'b0101);
    wait_grant(6, ok);
    checks++;
    if (!ok || {oS0, oS1} !== 2'd1) begin
      failures++;
      $display("FAIL rr_first got oC=%b sel=%0d want oC=0 sel=1", oC, {oS0, oS1});
    end
    iAck = 1'b1; tick(); iAck = 1'b0;
    wait_grant(6, ok);
    checks++;
    if (!ok || {oS0, oS1} !== 2'd3) begin
      failures++;
      $display("FAIL rr_second got oC=%b sel=%0d want oC=0 sel=3", oC, {oS0, oS1});
    end
    iAck = 1'b1; tick(); iAck = 1'b0;
    set_z(4'b1111);
    tick();
  endtask

  task automatic test_overflow();
    bit ok;
    int grants1 = 0;
    iZ0 = 1'b0;
    wait_grant(6, ok);
    checks++;
    if (!ok || {oS0, oS1} !== 2'd0) begin
      failures++;
      $display("FAIL ovf_hold_grant got oC=%b sel=%0d want oC=0 sel=0", oC, {oS0, oS1});
    end
    iZ1 = 1'b0; tick();
    checks++;
    if (oOvf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_first_edge got oOvf=%b want 0", oOvf);
    end
    iZ1 = 1'b1; tick();
    iZ1 = 1'b0; tick();
    checks++;
    if (oOvf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_second_edge got oOvf=%b want 1", oOvf);
    end
    iAck = 1'b1; tick(); iAck = 1'b0;
    checks++;
    if (oOvf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_one_cycle got oOvf=%b want 0", oOvf);
    end
    for (int i = 0; i < 12; i++) begin
      if (oC === 1'b0) begin
        if ({oS0, oS1} == 2'd1) grants1++;
        iAck = 1'b1;
      end
      tick();
      iAck = 1'b0;
    end
    checks++;
    if (grants1 != 1) begin
      failures++;
      $display("FAIL ovf_single_grant got %0d grants of index 1 want 1", grants1);
    end
    set_z(4'b1111);
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    int n_low = 0;
    iZ3 = 1'b0;
    wait_grant(6, ok);
    while (oC === 1'b0 && n_low < 20) begin n_low++; tick(); end
    checks++;
    if (n_low != TO || oTo !== 1'b1) begin
      failures++;
      $display("FAIL timeout_len got low=%0d oTo=%b want low=%0d oTo=1", n_low, oTo, TO);
    end
    tick();
    checks++;
    if (oC !== 1'b0 || {oS0, oS1} !== 2'd3 || oTo !== 1'b0) begin
      failures++;
      $display("FAIL timeout_regrant got oC=%b sel=%0d oTo=%b want 0/3/0", oC, {oS0, oS1}, oTo);
    end
    iAck = 1'b1; tick(); iAck = 1'b0;
    iZ3 = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    bit ok;
    int low_seen = 0;
    set_z(4'b0101);
    wait_grant(6, ok);
    tick();
    iRst_n = 1'b0;
    #1;
    checks++;
    if (oC !== 1'b1 || oTo !== 1'b0 || oOvf !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got oC=%b oTo=%b oOvf=%b want 1/0/0", oC, oTo, oOvf);
    end
    set_z(4'b1111);
    tick(); tick();
    iRst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (oC === 1'b0) low_seen++;
      tick();
    end
    checks++;
    if (low_seen != 0) begin
      failures++;
      $display("FAIL reset_pend_lost got %0d low cycles of oC want 0", low_seen);
    end
    iRst_n = 1'b0; iZ0 = 1'b0;
    tick();
    iRst_n = 1'b1;
    tick(); tick();
    checks++;
    if (oC !== 1'b0 || {oS0, oS1} !== 2'd0) begin
      failures++;
      $display("FAIL reset_held_low got oC=%b sel=%0d want oC=0 sel=0", oC, {oS0, oS1});
    end
    iAck = 1'b1; tick(); iAck = 1'b0;
    iZ0 = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [4:0] got, exp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      got = {oC, oS0, oS1, oOvf, oTo};
      exp = {m_gidx < 0, 2'(m_sel), m_ovf, m_to};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random cyc=%0d got {oC,sel,ovf,to}=%b want %b", c, got, exp);
      end
      for (int n = 0; n < 4; n++)
        if ($urandom_range(0, 3) == 0) begin
          case (n)
            0: iZ0 = ~iZ0;
            1: iZ1 = ~iZ1;
            2: iZ2 = ~iZ2;
            default: iZ3 = ~iZ3;
          endcase
        end
      iAck = ($urandom_range(0, 2) == 0);
      tick();
    end
    iAck = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_rr_after_3();
    test_overflow();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
